// File: rtl/bh1750_lux_bcd.sv
// ---------------------------------------------------------------------------
// bh1750_lux_bcd
//   Periodically samples the raw BH1750 light count, converts it to lux
//   (lux = raw*5/6, truncated), then to 5 BCD digits plus a leading-zero
//   blanking mask for the LED digit renderer.
//
//   Handshake: data_valid is a level qualifier, not a valid/ready pair. The
//   block samples data_in only on a sample tick while idle. Ticks that arrive
//   while a conversion is running are dropped. lux_done pulses for exactly one
//   clock when lux_bin/lux_bcd/digit_en take their new values, and those
//   outputs hold until the next lux_done.
//
// Ports
//   clk         in   1   system clock
//   rst         in   1   asynchronous active-low reset
//   data_valid  in   1   raw count valid (level)
//   data_in     in   16  raw BH1750 count
//   lux_bin     out  16  last converted lux, binary
//   lux_bcd     out  20  last converted lux, BCD ([19:16] = ten-thousands)
//   digit_en    out  5   per-digit enable, leading zeros blanked, bit0 always 1
//   lux_done    out  1   one-clock pulse on output update
//   busy        out  1   conversion in progress (high through the done cycle)
//
// Timing from sampling edge E: DIV on edges E+1..E+19, BCD on E+20..E+35,
// outputs and lux_done rise at E+36, lux_done and busy fall at E+37.
// ---------------------------------------------------------------------------
module bh1750_lux_bcd #(
  parameter int unsigned SAMPLE_DIV = 1_200_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [15:0] data_in,
  output logic [15:0] lux_bin,
  output logic [19:0] lux_bcd,
  output logic [4:0]  digit_en,
  output logic        lux_done,
  output logic        busy
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    BCD  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic              tick;

  // Division datapath: dividend shifts out MSB first into the remainder.
  logic [18:0]       dvd_q, dvd_d;
  logic [15:0]       quo_q, quo_d;
  logic [2:0]        rem_q, rem_d;
  logic [4:0]        bitcnt_q, bitcnt_d;

  // Double-dabble datapath.
  logic [15:0]       dd_bin_q, dd_bin_d;
  logic [19:0]       dd_bcd_q, dd_bcd_d;
  logic [3:0]        ddcnt_q, ddcnt_d;

  // Binary quotient kept until the done cycle.
  logic [15:0]       bin_q, bin_d;

  // Registered outputs.
  logic [15:0]       lux_bin_q, lux_bin_d;
  logic [19:0]       lux_bcd_q, lux_bcd_d;
  logic [4:0]        digit_en_q, digit_en_d;
  logic              lux_done_q, lux_done_d;
  logic              busy_q, busy_d;

  // Division step helpers.
  logic [3:0]        trial;
  logic              ge6;
  logic [2:0]        rem_next;
  logic [15:0]       quo_next;

  // Double-dabble adjusted BCD (before the shift).
  logic [19:0]       bcd_adj;

  // Digit i is shown when it or any more significant digit is nonzero.
  function automatic logic [4:0] lead_mask(input logic [19:0] b);
    logic [4:0] m;
    m[4] = |b[19:16];
    m[3] = m[4] | (|b[15:12]);
    m[2] = m[3] | (|b[11:8]);
    m[1] = m[2] | (|b[7:4]);
    m[0] = 1'b1;
    return m;
  endfunction

  // -------------------------------------------------------------------------
  // Free-running sample tick counter; never stalls.
  // -------------------------------------------------------------------------
  assign tick = (tick_cnt_q == TICK_MAX);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
  end

  // -------------------------------------------------------------------------
  // Combinational step logic for the two iterative datapaths.
  // -------------------------------------------------------------------------
  always_comb begin
    trial    = {rem_q, dvd_q[18]};
    ge6      = (trial >= 4'd6);
    // When trial < 6 its MSB is zero, so the low three bits are the remainder.
    rem_next = ge6 ? 3'(trial - 4'd6) : trial[2:0];
    // The 19-bit quotient never exceeds 54612, so the top bits shifted out
    // of the 16-bit register are always zero.
    quo_next = {quo_q[14:0], ge6};
  end

  always_comb begin
    bcd_adj = dd_bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (dd_bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = dd_bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and datapath control.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    bitcnt_d   = bitcnt_q;
    dd_bin_d   = dd_bin_q;
    dd_bcd_d   = dd_bcd_q;
    ddcnt_d    = ddcnt_q;
    bin_d      = bin_q;
    lux_bin_d  = lux_bin_q;
    lux_bcd_d  = lux_bcd_q;
    digit_en_d = digit_en_q;
    lux_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick && data_valid) begin
          // raw*5 as (raw<<2)+raw; 19 bits hold the maximum 327675.
          dvd_d    = {1'b0, data_in, 2'b00} + {3'b000, data_in};
          quo_d    = '0;
          rem_d    = '0;
          bitcnt_d = 5'd18;
          state_d  = DIV;
        end
      end

      DIV: begin
        dvd_d = {dvd_q[17:0], 1'b0};
        quo_d = quo_next;
        rem_d = rem_next;
        if (bitcnt_q == 5'd0) begin
          bin_d    = quo_next;
          dd_bin_d = quo_next;
          dd_bcd_d = '0;
          ddcnt_d  = 4'd15;
          state_d  = BCD;
        end else begin
          bitcnt_d = bitcnt_q - 5'd1;
        end
      end

      BCD: begin
        dd_bcd_d = {bcd_adj[18:0], dd_bin_q[15]};
        dd_bin_d = {dd_bin_q[14:0], 1'b0};
        if (ddcnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          ddcnt_d = ddcnt_q - 4'd1;
        end
      end

      DONE: begin
        lux_bin_d  = bin_q;
        lux_bcd_d  = dd_bcd_q;
        digit_en_d = lead_mask(dd_bcd_q);
        lux_done_d = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // busy stays high through the cycle in which lux_done is asserted.
  always_comb begin
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  // -------------------------------------------------------------------------
  // Registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      bitcnt_q   <= '0;
      dd_bin_q   <= '0;
      dd_bcd_q   <= '0;
      ddcnt_q    <= '0;
      bin_q      <= '0;
      lux_bin_q  <= '0;
      lux_bcd_q  <= '0;
      digit_en_q <= 5'b00001;
      lux_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      dvd_q      <= dvd_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      bitcnt_q   <= bitcnt_d;
      dd_bin_q   <= dd_bin_d;
      dd_bcd_q   <= dd_bcd_d;
      ddcnt_q    <= ddcnt_d;
      bin_q      <= bin_d;
      lux_bin_q  <= lux_bin_d;
      lux_bcd_q  <= lux_bcd_d;
      digit_en_q <= digit_en_d;
      lux_done_q <= lux_done_d;
      busy_q     <= busy_d;
    end
  end

  assign lux_bin  = lux_bin_q;
  assign lux_bcd  = lux_bcd_q;
  assign digit_en = digit_en_q;
  assign lux_done = lux_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bh1750_lux_bcd.sv
// ---------------------------------------------------------------------------
// tb_bh1750_lux_bcd
//   Directed bench for bh1750_lux_bcd with SAMPLE_DIV=40. Each conversion is
//   launched by holding data_valid high; the sampling edge is recognised by
//   busy rising, after which data_in is scrambled so the result must come from
//   the latched value. Expected results come from hand-computed tables and,
//   for the pseudo-random sweep, from an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_bh1750_lux_bcd;

  localparam int SAMPLE_DIV = 40;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] lux_bin;
  logic [19:0] lux_bcd;
  logic [4:0]  digit_en;
  logic        lux_done;
  logic        busy;

  always #5 clk = ~clk;

  bh1750_lux_bcd #(.SAMPLE_DIV(SAMPLE_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data_in    (data_in),
    .lux_bin    (lux_bin),
    .lux_bcd    (lux_bcd),
    .digit_en   (digit_en),
    .lux_done   (lux_done),
    .busy       (busy)
  );

  // -------------------------------------------------------------------------
  // Scoreboard: expected entries are {lux_bin[15:0], lux_bcd[19:0], digit_en[4:0]}
  // -------------------------------------------------------------------------
  logic [40:0] exp_q[$];
  logic [40:0] last_exp;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [40:0] model(input logic [15:0] d);
    int unsigned lux;
    int unsigned t;
    int unsigned p;
    logic [19:0] bcd;
    logic [4:0]  en;
    lux = ({16'd0, d} * 32'd5) / 32'd6;
    t   = lux;
    for (int i = 0; i < 5; i++) begin
      bcd[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    en[0] = 1'b1;
    p = 1;
    for (int i = 1; i < 5; i++) begin
      p = p * 10;
      en[i] = (lux >= p);
    end
    return {lux[15:0], bcd, en};
  endfunction

  // -------------------------------------------------------------------------
  // Driver: one conversion, checked for latency, pulse shape and result.
  // Called at a negedge; returns at the negedge after lux_done falls.
  // -------------------------------------------------------------------------
  task automatic run_conv(input logic [15:0] d, input logic [40:0] exp);
    int n;
    logic [40:0] e;
    exp_q.push_back(exp);
    data_valid = 1'b1;
    data_in    = d;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sample_seen", 32'(busy), 32'd1);
    // Scramble the input right after the sampling edge.
    data_in = ~d;
    n = 0;
    while (lux_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", 32'(n), 32'd36);
    check("busy_at_done", 32'(busy), 32'd1);
    e = exp_q.pop_front();
    last_exp = e;
    check("lux_bin", 32'(lux_bin), 32'(e[40:25]));
    check("lux_bcd", 32'(lux_bcd), 32'(e[24:5]));
    check("digit_en", 32'(digit_en), 32'(e[4:0]));
    @(negedge clk);
    check("done_fall", 32'(lux_done), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Hand-computed directed vectors.
  // -------------------------------------------------------------------------
  logic [15:0] vin  [12];
  logic [15:0] vbin [12];
  logic [19:0] vbcd [12];
  logic [4:0]  ven  [12];

  initial begin
    int done_cnt;
    int busy_cnt;
    int n;
    logic [15:0] d;

    vin  = '{16'd0,     16'd120,   16'd6,     16'd1,     16'd65535, 16'd12000,
             16'd11,    16'd12,    16'd1199,  16'd1200,  16'd65534, 16'd5};
    vbin = '{16'd0,     16'd100,   16'd5,     16'd0,     16'd54612, 16'd10000,
             16'd9,     16'd10,    16'd999,   16'd1000,  16'd54611, 16'd4};
    vbcd = '{20'h00000, 20'h00100, 20'h00005, 20'h00000, 20'h54612, 20'h10000,
             20'h00009, 20'h00010, 20'h00999, 20'h01000, 20'h54611, 20'h00004};
    ven  = '{5'b00001,  5'b00111,  5'b00001,  5'b00001,  5'b11111,  5'b11111,
             5'b00001,  5'b00011,  5'b00111,  5'b01111,  5'b11111,  5'b00001};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_lux_bin", 32'(lux_bin), 32'd0);
    check("rst_lux_bcd", 32'(lux_bcd), 32'd0);
    check("rst_digit_en", 32'(digit_en), 32'b00001);
    check("rst_lux_done", 32'(lux_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      run_conv(vin[i], {vbin[i], vbcd[i], ven[i]});
    end

    // Pseudo-random / strided sweep against the reference model.
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 1) d = 16'($urandom_range(0, 65535));
      else            d = 16'(k * 1693);
      run_conv(d, model(d));
    end

    // No valid data across three ticks: nothing moves.
    data_valid = 1'b0;
    data_in    = 16'd4321;
    done_cnt   = 0;
    busy_cnt   = 0;
    for (int c = 0; c < 3 * SAMPLE_DIV + 5; c++) begin
      @(negedge clk);
      if (lux_done === 1'b1) done_cnt++;
      if (busy !== 1'b0)     busy_cnt++;
    end
    check("idle_no_done", 32'(done_cnt), 32'd0);
    check("idle_no_busy", 32'(busy_cnt), 32'd0);
    check("idle_hold_bin", 32'(lux_bin), 32'(last_exp[40:25]));
    check("idle_hold_bcd", 32'(lux_bcd), 32'(last_exp[24:5]));
    check("idle_hold_en", 32'(digit_en), 32'(last_exp[4:0]));

    // Reset in the middle of a conversion.
    data_valid = 1'b1;
    data_in    = 16'd12000;
    n = 0;
    while (busy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_sample_seen", 32'(busy), 32'd1);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_lux_bin", 32'(lux_bin), 32'd0);
    check("midrst_lux_bcd", 32'(lux_bcd), 32'd0);
    check("midrst_digit_en", 32'(digit_en), 32'b00001);
    check("midrst_busy", 32'(busy), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (lux_done === 1'b1) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run_conv(16'd1200, {16'd1000, 20'h01000, 5'b01111});
    run_conv(16'd120,  {16'd100,  20'h00100, 5'b00111});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
